// File: rtl/game_ram_scheduler_pkg.sv
// Shared definitions for the morse RAM scheduler: game phase encodings,
// grant selection codes and default geometry.
package game_ram_scheduler_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 10;
  localparam int unsigned DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    S_START  = 2'd0,
    S_P1TURN = 2'd1,
    S_P2TURN = 2'd2,
    S_RESULT = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    G_NONE    = 2'd0,
    G_P1_WR   = 2'd1,
    G_P2_RD   = 2'd2,
    G_DISP_RD = 2'd3
  } grant_e;

endpackage

// File: rtl/game_ram_scheduler_if.sv
// Request/ack handshakes for the three RAM clients plus the RAM port itself.
// slave is the scheduler's view; master is the clients'/RAM's view.
interface game_ram_scheduler_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 10
);
  logic              p1_wr_req;
  logic [DATA_W-1:0] p1_wr_data;
  logic              p1_wr_ack;
  logic              p2_rd_req;
  logic              p2_rd_ack;
  logic              p2_rd_valid;
  logic [DATA_W-1:0] p2_rd_data;
  logic              disp_rd_req;
  logic [ADDR_W-1:0] disp_rd_addr;
  logic              disp_rd_ack;
  logic              disp_rd_valid;
  logic [DATA_W-1:0] disp_rd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  p1_wr_req, p1_wr_data, p2_rd_req, disp_rd_req, disp_rd_addr, ram_q,
    output p1_wr_ack, p2_rd_ack, p2_rd_valid, p2_rd_data,
           disp_rd_ack, disp_rd_valid, disp_rd_data, ram_addr, ram_wren, ram_data
  );

  modport master (
    output p1_wr_req, p1_wr_data, p2_rd_req, disp_rd_req, disp_rd_addr, ram_q,
    input  p1_wr_ack, p2_rd_ack, p2_rd_valid, p2_rd_data,
           disp_rd_ack, disp_rd_valid, disp_rd_data, ram_addr, ram_wren, ram_data
  );
endinterface

// File: rtl/game_ram_scheduler_ram_grant_arbiter.sv
// Fixed-priority single-access grant for the morse RAM: player1 write, then
// player2 read, then display read. Address holds its last value when idle.
module game_ram_scheduler_ram_grant_arbiter
  import game_ram_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              wr_ok_i,
  input  logic              rd_ok_i,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [ADDR_W-1:0] p2_addr_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  input  logic [ADDR_W-1:0] hold_addr_i,
  output grant_e            grant_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wren_o
);

  always_comb begin
    grant_o    = G_NONE;
    ram_addr_o = hold_addr_i;
    ram_wren_o = 1'b0;
    if (wr_ok_i) begin
      grant_o    = G_P1_WR;
      ram_addr_o = p1_addr_i;
      ram_wren_o = 1'b1;
    end else if (rd_ok_i) begin
      grant_o    = G_P2_RD;
      ram_addr_o = p2_addr_i;
    end else if (disp_req_i) begin
      grant_o    = G_DISP_RD;
      ram_addr_o = disp_addr_i;
    end
  end

endmodule

// File: rtl/game_ram_scheduler.sv
// Game phase sequencer and RAM access scheduler for the shared morse RAM:
// owns the phase FSM, the player pointers and the read-return registers.
module game_ram_scheduler
  import game_ram_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   done_pulse,
  game_ram_scheduler_if.slave    bus,
  output logic [1:0]             state,
  output logic [ADDR_W:0]        p1_count,
  output logic [ADDR_W:0]        p2_addr,
  output logic                   p1_full,
  output logic                   p2_exhausted
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

  phase_e            state_q, state_d;
  logic [ADDR_W:0]   p1_count_q, p1_count_d;
  logic [ADDR_W:0]   p2_addr_q, p2_addr_d;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              p2_valid_q, disp_valid_q;
  logic [DATA_W-1:0] p2_data_q, disp_data_q;
  logic              full, exhausted, wr_ok, rd_ok, last_read;
  grant_e            grant;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;

  assign full      = (p1_count_q == CNT_MAX);
  assign exhausted = (p2_addr_q == p1_count_q);
  assign wr_ok     = bus.p1_wr_req && (state_q == S_P1TURN) && !full;
  assign rd_ok     = bus.p2_rd_req && (state_q == S_P2TURN) && !exhausted;

  game_ram_scheduler_ram_grant_arbiter #(.ADDR_W(ADDR_W)) u_arb (
    .wr_ok_i    (wr_ok),
    .rd_ok_i    (rd_ok),
    .disp_req_i (bus.disp_rd_req),
    .p1_addr_i  (p1_count_q[ADDR_W-1:0]),
    .p2_addr_i  (p2_addr_q[ADDR_W-1:0]),
    .disp_addr_i(bus.disp_rd_addr),
    .hold_addr_i(ram_addr_q),
    .grant_o    (grant),
    .ram_addr_o (ram_addr),
    .ram_wren_o (ram_wren)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_START;
    else         state_q <= state_d;
  end

  // Pointer moves and phase change share an edge when done_pulse meets a grant;
  // the final player2 read ends the turn on its own grant edge.
  always_comb begin
    state_d    = state_q;
    p1_count_d = p1_count_q;
    p2_addr_d  = p2_addr_q;
    last_read  = (grant == G_P2_RD) && ((p2_addr_q + CNT_ONE) == p1_count_q);
    if (grant == G_P1_WR) p1_count_d = p1_count_q + CNT_ONE;
    if (grant == G_P2_RD) p2_addr_d  = p2_addr_q + CNT_ONE;
    case (state_q)
      S_START: if (done_pulse) begin
        state_d    = S_P1TURN;
        p1_count_d = '0;
        p2_addr_d  = '0;
      end
      S_P1TURN: if (done_pulse) state_d = S_P2TURN;
      S_P2TURN: if (done_pulse || last_read) state_d = S_RESULT;
      S_RESULT: if (done_pulse) state_d = S_START;
      default:  state_d = S_START;
    endcase
  end

  always_comb begin
    state             = state_q;
    p1_count          = p1_count_q;
    p2_addr           = p2_addr_q;
    p1_full           = full;
    p2_exhausted      = exhausted;
    bus.p1_wr_ack     = (grant == G_P1_WR);
    bus.p2_rd_ack     = (grant == G_P2_RD);
    bus.disp_rd_ack   = (grant == G_DISP_RD);
    bus.ram_addr      = ram_addr;
    bus.ram_wren      = ram_wren;
    bus.ram_data      = (grant == G_P1_WR) ? bus.p1_wr_data : '0;
    bus.p2_rd_valid   = p2_valid_q;
    bus.disp_rd_valid = disp_valid_q;
    // RAM data is live during the valid cycle and held from the register afterwards.
    bus.p2_rd_data    = p2_valid_q   ? bus.ram_q : p2_data_q;
    bus.disp_rd_data  = disp_valid_q ? bus.ram_q : disp_data_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      p1_count_q   <= '0;
      p2_addr_q    <= '0;
      ram_addr_q   <= '0;
      p2_valid_q   <= 1'b0;
      disp_valid_q <= 1'b0;
      p2_data_q    <= '0;
      disp_data_q  <= '0;
    end else begin
      p1_count_q   <= p1_count_d;
      p2_addr_q    <= p2_addr_d;
      ram_addr_q   <= ram_addr;
      p2_valid_q   <= (grant == G_P2_RD);
      disp_valid_q <= (grant == G_DISP_RD);
      if (p2_valid_q)   p2_data_q   <= bus.ram_q;
      if (disp_valid_q) disp_data_q <= bus.ram_q;
    end
  end

endmodule

// File: tb/tb_game_ram_scheduler.sv
// Directed bench for game_ram_scheduler with a behavioural 16x10 synchronous RAM.
module tb_game_ram_scheduler;

  logic       clock = 1'b0;
  logic       resetn;
  logic       done_pulse;
  logic [1:0] state;
  logic [4:0] p1_count, p2_addr;
  logic       p1_full, p2_exhausted;
  int         checks = 0;
  int         failures = 0;
  int         acks;
  logic [9:0] mem [16];

  game_ram_scheduler_if #(.ADDR_W(4), .DATA_W(10)) bus ();

  game_ram_scheduler #(.ADDR_W(4), .DATA_W(10), .DEPTH(16)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .done_pulse  (done_pulse),
    .bus         (bus.slave),
    .state       (state),
    .p1_count    (p1_count),
    .p2_addr     (p2_addr),
    .p1_full     (p1_full),
    .p2_exhausted(p2_exhausted)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    @(negedge clock); done_pulse = 1'b1;
    @(negedge clock); done_pulse = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; done_pulse = 1'b0;
    bus.p1_wr_req = 1'b0; bus.p1_wr_data = '0; bus.p2_rd_req = 1'b0;
    bus.disp_rd_req = 1'b0; bus.disp_rd_addr = '0; bus.ram_q = '0;
    repeat (3) @(negedge clock);
    check("rst_state", 32'(state), 0);
    check("rst_p1_count", 32'(p1_count), 0);
    check("rst_p2_addr", 32'(p2_addr), 0);
    check("rst_acks", 32'({bus.p1_wr_ack, bus.p2_rd_ack, bus.disp_rd_ack}), 0);
    check("rst_valids", 32'({bus.p2_rd_valid, bus.disp_rd_valid}), 0);
    check("rst_wren", 32'(bus.ram_wren), 0);
    check("rst_rd_data", 32'({bus.p2_rd_data, bus.disp_rd_data}), 0);
    resetn = 1'b1;

    // Phase walk with no requests
    pulse(); check("walk_p1", 32'(state), 1);
    pulse(); check("walk_p2", 32'(state), 2);
    bus.p1_wr_req = 1'b1; #1;
    check("wrong_phase_wr_ack", 32'(bus.p1_wr_ack), 0);
    check("wrong_phase_wren", 32'(bus.ram_wren), 0);
    bus.p1_wr_req = 1'b0;
    pulse(); check("walk_result", 32'(state), 3);
    check("walk_p1_count", 32'(p1_count), 0);
    pulse(); check("walk_start", 32'(state), 0);

    // Three writes in P1TURN
    pulse(); check("g1_p1turn", 32'(state), 1);
    bus.p1_wr_req = 1'b1; bus.p1_wr_data = 10'h155; #1;
    check("wr0_ack", 32'(bus.p1_wr_ack), 1);
    check("wr0_addr", 32'(bus.ram_addr), 0);
    check("wr0_wren", 32'(bus.ram_wren), 1);
    check("wr0_data", 32'(bus.ram_data), 32'h155);
    @(negedge clock); bus.p1_wr_data = 10'h2AA; #1;
    check("wr1_addr", 32'(bus.ram_addr), 1);
    check("wr1_ack", 32'(bus.p1_wr_ack), 1);
    @(negedge clock); bus.p1_wr_data = 10'h3FF; #1;
    check("wr2_addr", 32'(bus.ram_addr), 2);
    check("wr2_data", 32'(bus.ram_data), 32'h3FF);
    @(negedge clock); bus.p1_wr_req = 1'b0; #1;
    check("wr_count", 32'(p1_count), 3);
    check("idle_ack", 32'(bus.p1_wr_ack), 0);
    check("idle_wren", 32'(bus.ram_wren), 0);
    check("idle_addr_hold", 32'(bus.ram_addr), 2);

    // Player2 reads the three words back
    pulse(); check("g1_p2turn", 32'(state), 2);
    check("g1_not_exhausted", 32'(p2_exhausted), 0);
    bus.p2_rd_req = 1'b1; #1;
    check("rd0_ack", 32'(bus.p2_rd_ack), 1);
    check("rd0_addr", 32'(bus.ram_addr), 0);
    @(posedge clock); #1;
    check("rd0_valid", 32'(bus.p2_rd_valid), 1);
    check("rd0_data", 32'(bus.p2_rd_data), 32'h155);
    @(negedge clock); #1;
    check("rd1_addr", 32'(bus.ram_addr), 1);
    @(posedge clock); #1;
    check("rd1_data", 32'(bus.p2_rd_data), 32'h2AA);
    @(negedge clock); #1;
    check("rd2_ack", 32'(bus.p2_rd_ack), 1);
    check("rd2_addr", 32'(bus.ram_addr), 2);
    @(posedge clock); #1;
    check("rd2_data", 32'(bus.p2_rd_data), 32'h3FF);
    check("rd2_valid", 32'(bus.p2_rd_valid), 1);
    check("auto_result", 32'(state), 3);
    check("exhausted", 32'(p2_exhausted), 1);
    @(negedge clock); #1;
    check("rd_after_result_ack", 32'(bus.p2_rd_ack), 0);
    bus.p2_rd_req = 1'b0;
    @(posedge clock); #1;
    check("rd_valid_drop", 32'(bus.p2_rd_valid), 0);
    check("rd_data_hold", 32'(bus.p2_rd_data), 32'h3FF);

    // Display read in RESULT
    @(negedge clock); bus.disp_rd_req = 1'b1; bus.disp_rd_addr = 4'd1; #1;
    check("disp_ack", 32'(bus.disp_rd_ack), 1);
    check("disp_addr", 32'(bus.ram_addr), 1);
    @(posedge clock); #1;
    check("disp_valid", 32'(bus.disp_rd_valid), 1);
    check("disp_data", 32'(bus.disp_rd_data), 32'h2AA);
    @(negedge clock); bus.disp_rd_req = 1'b0;

    // Game 2: player2 and display contend
    pulse(); check("g2_start", 32'(state), 0);
    pulse(); check("g2_p1_clear", 32'(p1_count), 0);
    bus.p1_wr_req = 1'b1; bus.p1_wr_data = 10'h011;
    @(negedge clock); bus.p1_wr_data = 10'h022;
    @(negedge clock); bus.p1_wr_req = 1'b0;
    check("g2_count", 32'(p1_count), 2);
    pulse(); check("g2_p2turn", 32'(state), 2);
    bus.p2_rd_req = 1'b1; bus.disp_rd_req = 1'b1; bus.disp_rd_addr = 4'd1; #1;
    check("prio_p2_ack", 32'(bus.p2_rd_ack), 1);
    check("prio_disp_wait", 32'(bus.disp_rd_ack), 0);
    check("prio_addr", 32'(bus.ram_addr), 0);
    @(negedge clock); bus.p2_rd_req = 1'b0; #1;
    check("prio_disp_ack", 32'(bus.disp_rd_ack), 1);
    check("prio_disp_addr", 32'(bus.ram_addr), 1);
    check("prio_p2_data", 32'(bus.p2_rd_data), 32'h011);
    @(posedge clock); #1;
    check("prio_disp_data", 32'(bus.disp_rd_data), 32'h022);
    check("prio_p2_valid_drop", 32'(bus.p2_rd_valid), 0);
    @(negedge clock); bus.disp_rd_req = 1'b0;

    // Game 3: 17 held writes fill the RAM
    pulse(); pulse(); pulse();
    check("g3_p1turn", 32'(state), 1);
    bus.p1_wr_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 17; i++) begin
      bus.p1_wr_data = 10'(32'h100 + i); #1;
      if (bus.p1_wr_ack) acks++;
      @(negedge clock);
    end
    check("full_acks", 32'(acks), 16);
    check("full_count", 32'(p1_count), 16);
    check("full_flag", 32'(p1_full), 1);
    check("full_17th_ack", 32'(bus.p1_wr_ack), 0);
    check("full_17th_wren", 32'(bus.ram_wren), 0);
    bus.p1_wr_req = 1'b0;

    // Reset while a player2 read is outstanding
    pulse(); check("g3_p2turn", 32'(state), 2);
    bus.p2_rd_req = 1'b1; #1;
    check("rst_rd_ack", 32'(bus.p2_rd_ack), 1);
    resetn = 1'b0; #1;
    check("rstmid_state", 32'(state), 0);
    check("rstmid_ptrs", 32'({p1_count, p2_addr}), 0);
    @(posedge clock); #1;
    check("rstmid_no_valid", 32'(bus.p2_rd_valid), 0);
    check("rstmid_data", 32'(bus.p2_rd_data), 0);
    bus.p2_rd_req = 1'b0;
    @(negedge clock); resetn = 1'b1;
    @(negedge clock);
    check("post_rst_state", 32'(state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
